mux_arb_rr: RTL and testbench

MUX_ARB_RR -- requirements
Module: mux_arb_rr

---
 rtl/mux_arb_rr.sv | 105 ++++++++++
 tb/tb_mux_arb_rr.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mux_arb_rr.sv
// Round-robin N:1 arbiter/mux with a single-entry registered output stage.
// Optional MUX_ARB_MANUAL_SEL_EN adds man_en/man_sel for a forced channel grant.
module mux_arb_rr #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 6,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef MUX_ARB_MANUAL_SEL_EN
  input  logic                      man_en,
  input  logic [SEL_W-1:0]          man_sel,
`endif
  output logic [SEL_W-1:0]          out_chan
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;

  logic             gnt_hit;
  logic [SEL_W-1:0] gnt_idx;
  logic             manual;
  logic             load_en;
  logic             xfer;

  // Grant search: first requester at or after ptr, wrapping.
  always_comb begin
    int j;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    manual  = 1'b0;
    j       = 0;
`ifdef MUX_ARB_MANUAL_SEL_EN
    manual = man_en;
    if (man_en) begin
      if (int'(man_sel) < CHANNELS) begin
        if (in_valid[man_sel]) begin
          gnt_hit = 1'b1;
          gnt_idx = man_sel;
        end
      end
    end else
`endif
    begin
      for (int k = 0; k < CHANNELS; k++) begin
        j = int'(ptr_q) + k;
        if (j >= CHANNELS) j = j - CHANNELS;
        if (!gnt_hit && in_valid[j]) begin
          gnt_hit = 1'b1;
          gnt_idx = SEL_W'(j);
        end
      end
    end
  end

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = gnt_hit && load_en && !reset;

  always_comb begin
    in_ready    = '0;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      in_ready    = CHANNELS'(1) << gnt_idx;
      out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
      out_chan_d  = gnt_idx;
      out_valid_d = 1'b1;
      if (!manual) begin
        if (gnt_idx == SEL_W'(CHANNELS - 1)) ptr_d = '0;
        else ptr_d = gnt_idx + 1'b1;
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Bench for mux_arb_rr (CHANNELS=6, WIDTH=4): directed steps plus
// randomized traffic against a behavioural arbiter model.
module tb_mux_arb_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] in_data;
  logic [5:0]  in_valid;
  logic [5:0]  in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_chan;
  logic        man_en;
  logic [2:0]  man_sel;

  int       total = 0;
  int       bad   = 0;
  int       m_ptr;
  int       m_chan;
  bit       m_valid;
  bit [3:0] m_data;

  always #5 clk = ~clk;

  mux_arb_rr #(.WIDTH(4), .CHANNELS(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef MUX_ARB_MANUAL_SEL_EN
    .man_en   (man_en),
    .man_sel  (man_sel),
`endif
    .out_chan (out_chan)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_grant();
`ifdef MUX_ARB_MANUAL_SEL_EN
    if (man_en) begin
      if (int'(man_sel) < 6 && in_valid[man_sel]) return int'(man_sel);
      return -1;
    end
`endif
    for (int k = 0; k < 6; k++)
      if (in_valid[(m_ptr + k) % 6]) return (m_ptr + k) % 6;
    return -1;
  endfunction

  // One clock: apply inputs, check in_ready, clock, update model, check outputs.
  task automatic step(input bit rst, input logic [5:0] v, input bit ordy);
    int         g;
    bit         load;
    logic [5:0] exp_rdy;
    reset     = rst;
    in_valid  = v;
    out_ready = ordy;
    #2;
    g       = m_grant();
    load    = !m_valid || ordy;
    exp_rdy = (!rst && load && g >= 0) ? 6'(1 << g) : 6'd0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
    end else if (load && g >= 0) begin
      m_data  = in_data[g*4 +: 4];
      m_chan  = g;
      m_valid = 1;
      if (!man_en) m_ptr = (g + 1) % 6;
    end else if (load) begin
      m_valid = 0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
  endtask

  initial begin
    reset = 1; in_valid = 0; out_ready = 0; man_en = 0; man_sel = 0;
    in_data = 0;
    m_ptr = 0; m_chan = 0; m_valid = 0; m_data = 0;
    @(posedge clk);
    #1;
    step(1, 6'h3f, 1);
    step(1, 6'h3f, 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_chan", 32'(out_chan), 0);

    for (int i = 0; i < 6; i++) in_data[i*4 +: 4] = 4'(i + 1);
    for (int k = 0; k < 7; k++) begin
      step(0, 6'h3f, 1);
      chk("rr_chan", 32'(out_chan), 32'(k % 6));
      chk("rr_data", 32'(out_data), 32'(k % 6 + 1));
      chk("rr_valid", 32'(out_valid), 1);
    end

    step(1, 6'h00, 1);
    for (int k = 0; k < 3; k++) step(0, 6'h3f, 1);
    chk("hold_pre", 32'(out_chan), 2);
    for (int k = 0; k < 3; k++) begin
      step(0, 6'h3f, 0);
      chk("hold_chan", 32'(out_chan), 2);
      chk("hold_data", 32'(out_data), 3);
    end
    step(0, 6'h3f, 1);
    chk("hold_next", 32'(out_chan), 3);

    step(1, 6'h00, 1);
    step(0, 6'b010000, 1);
    step(0, 6'b100001, 1);
    chk("wrap_a", 32'(out_chan), 5);
    step(0, 6'b100001, 1);
    chk("wrap_b", 32'(out_chan), 0);
    step(0, 6'b100001, 1);
    chk("wrap_c", 32'(out_chan), 5);

    step(0, 6'h00, 1);
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_data", 32'(out_data), 6);
    chk("drain_chan", 32'(out_chan), 5);

    step(0, 6'b001000, 1);
    step(1, 6'h3f, 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_data", 32'(out_data), 0);
    step(0, 6'h3f, 1);
    chk("midrst_grant", 32'(out_chan), 0);

`ifdef MUX_ARB_MANUAL_SEL_EN
    step(1, 6'h00, 1);
    step(0, 6'b000001, 1);
    man_en = 1; man_sel = 3;
    for (int k = 0; k < 3; k++) begin
      step(0, 6'h3f, 1);
      chk("man_chan", 32'(out_chan), 3);
    end
    man_sel = 7;
    step(0, 6'h3f, 1);
    chk("man_oob", 32'(out_valid), 0);
    man_en = 0;
    step(0, 6'h3f, 1);
    chk("man_ptr", 32'(out_chan), 1);
`endif

    for (int n = 0; n < 400; n++) begin
      in_data = 24'($urandom);
`ifdef MUX_ARB_MANUAL_SEL_EN
      man_en  = ($urandom_range(0, 5) == 0);
      man_sel = 3'($urandom);
`endif
      step($urandom_range(0, 29) == 0, 6'($urandom),
           $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
